// File: rtl/darkriscv_dbus_pkg.sv
// darkriscv_dbus_pkg
//   Shared definitions for the darkriscv data-bus bridge. It holds the FSM
//   state encoding, the one-hot DLEN access-size codes, the default abort
//   timeout and the read data returned on an aborted read.
package darkriscv_dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] DLEN_BYTE = 3'b001;
  localparam logic [2:0] DLEN_HALF = 3'b010;
  localparam logic [2:0] DLEN_WORD = 3'b100;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [31:0] ABORT_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/darkriscv_dbus_lane.sv
// darkriscv_dbus_lane
//   Combinational lane decoder. It turns the access size and the low
//   address bits into memory byte enables, and flags whether the access is
//   naturally aligned with a one-hot size code.
//   Ports:
//     dlen    in  3  access size, one-hot (byte/half/word)
//     addr_lo in  2  DADDR[1:0]
//     be      out 4  byte enables (only meaningful when legal=1)
//     legal   out 1  size is one-hot and the address is aligned to it
module darkriscv_dbus_lane
  import darkriscv_dbus_pkg::*;
(
  input  logic [2:0] dlen,
  input  logic [1:0] addr_lo,
  output logic [3:0] be,
  output logic       legal
);

  always_comb begin
    be    = 4'b0000;
    legal = 1'b0;
    case (dlen)
      DLEN_WORD: begin
        be    = 4'b1111;
        legal = (addr_lo == 2'b00);
      end
      DLEN_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        legal = ~addr_lo[0];
      end
      DLEN_BYTE: begin
        be    = 4'b0001 << addr_lo;
        legal = 1'b1;
      end
      default: begin
        // Not one-hot: no lanes, illegal.
        be    = 4'b0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/darkriscv_dbus.sv
// darkriscv_dbus
//   Bridge between the darkriscv CPU data port and a simple single-cycle-ack
//   memory. Each legal request stalls the CPU, issues one memory strobe from
//   registered copies of the request, and releases the CPU for one RESP
//   cycle once the memory acknowledges or the access times out.
//   Ports:
//     CLK, RES                  clock (rising edge), async active-low reset
//     DADDR/DATAO/DLEN          CPU address, lane-placed write data, size
//     DRD/DWR/DAS               read / write request, address strobe
//     DATAI                     registered read data to the CPU
//     HLT                       CPU stall
//     MEM_ADDR/MEM_WDATA/MEM_BE memory word address, write data, lanes
//     MEM_RE/MEM_WE             memory read / write strobes
//     MEM_RDATA/MEM_ACK         memory read data and single-cycle completion
//     ERR_CLR                   clears the sticky error flag
//     BUS_ERR/ERR_ADDR          sticky error flag, address of latest error
//     dbg_state                 current FSM state, for observation only
//
// Handshake: the CPU offers a request by holding DAS with DRD or DWR; the
// bridge accepts it in the same cycle it is offered while idle, and HLT
// acts as the inverse of ready -- the CPU must keep waiting while HLT=1 and
// may consume DATAI and present its next request once HLT drops. On the
// memory side the strobe is the valid and MEM_ACK the one-cycle completion;
// the strobe stays asserted and stable until MEM_ACK or the timeout.
module darkriscv_dbus
  import darkriscv_dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAO,
  input  logic [2:0]  DLEN,
  input  logic        DRD,
  input  logic        DWR,
  input  logic        DAS,
  output logic [31:0] DATAI,
  output logic        HLT,
  output logic [29:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BE,
  output logic        MEM_RE,
  output logic        MEM_WE,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  input  logic        ERR_CLR,
  output logic        BUS_ERR,
  output logic [31:0] ERR_ADDR,
  output state_t      dbg_state
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] datai_q, datai_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic [3:0]  lane_be;
  logic        lane_legal;
  logic        req_any;
  logic        req_ok;
  logic        err_set;
  logic [7:0]  cnt_inc;

  darkriscv_dbus_lane u_lane (
    .dlen    (DLEN),
    .addr_lo (DADDR[1:0]),
    .be      (lane_be),
    .legal   (lane_legal)
  );

  // DAS without a direction is not a request at all; both directions at
  // once is a request, but an illegal one.
  assign req_any = DAS & (DRD | DWR);
  assign req_ok  = req_any & ~(DRD & DWR) & lane_legal;
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    datai_d    = datai_q;
    err_addr_d = err_addr_q;
    err_set    = 1'b0;
    HLT        = 1'b0;
    MEM_RE     = 1'b0;
    MEM_WE     = 1'b0;
    MEM_BE     = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (req_ok) begin
          HLT     = 1'b1;
          addr_d  = DADDR;
          be_d    = lane_be;
          wdata_d = DATAO;
          rd_d    = DRD;
          cnt_d   = 8'd0;
          state_d = ST_REQ;
        end else if (req_any) begin
          // Rejected without stalling: the CPU sees zero data and an error.
          datai_d    = 32'h0000_0000;
          err_set    = 1'b1;
          err_addr_d = DADDR;
        end
      end

      ST_REQ: begin
        HLT    = 1'b1;
        MEM_RE = rd_q;
        MEM_WE = ~rd_q;
        MEM_BE = be_q;
        if (MEM_ACK) begin
          // Checked before the timeout so a late ack still completes.
          if (rd_q) begin
            datai_d = MEM_RDATA;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            err_set    = 1'b1;
            err_addr_d = addr_q;
            if (rd_q) begin
              datai_d = ABORT_DATA;
            end
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new error outranks a clear in the same cycle.
    bus_err_d = err_set | (bus_err_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0000_0000;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0000_0000;
      rd_q       <= 1'b0;
      cnt_q      <= 8'd0;
      datai_q    <= 32'h0000_0000;
      bus_err_q  <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      datai_q    <= datai_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign DATAI     = datai_q;
  assign MEM_ADDR  = addr_q[31:2];
  assign MEM_WDATA = wdata_q;
  assign BUS_ERR   = bus_err_q;
  assign ERR_ADDR  = err_addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_darkriscv_dbus.sv
// tb_darkriscv_dbus
//   Directed bench for darkriscv_dbus. A transaction-level model tracks what
//   each output must be per cycle; one compare process checks it on every
//   falling edge, and literal expectations pin the key scenarios.
module tb_darkriscv_dbus;
  import darkriscv_dbus_pkg::*;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] DADDR, DATAO, MEM_RDATA;
  logic [2:0]  DLEN;
  logic        DRD, DWR, DAS, MEM_ACK, ERR_CLR;
  logic [31:0] DATAI, MEM_WDATA, ERR_ADDR;
  logic        HLT, MEM_RE, MEM_WE, BUS_ERR;
  logic [29:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  state_t      dbg_state;

  darkriscv_dbus #(.TIMEOUT(TO)) dut (
    .CLK(clk), .RES(rst_n),
    .DADDR(DADDR), .DATAO(DATAO), .DLEN(DLEN),
    .DRD(DRD), .DWR(DWR), .DAS(DAS),
    .DATAI(DATAI), .HLT(HLT),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BE(MEM_BE),
    .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .ERR_CLR(ERR_CLR), .BUS_ERR(BUS_ERR), .ERR_ADDR(ERR_ADDR),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic        chk_en = 1'b0;
  logic        exp_hlt, exp_re, exp_we, exp_bus_err, nxt_bus_err;
  logic [3:0]  exp_be;
  logic [29:0] exp_maddr;
  logic [31:0] exp_wdata, exp_datai, exp_err_addr, nxt_datai, nxt_err_addr;

  // Written only by the compare process; main reads snapshots.
  int hlt_cnt = 0;
  int strobe_cnt = 0;
  logic [3:0]  last_be = 4'b0;
  logic [29:0] last_maddr = '0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic int nbytes(input logic [2:0] len);
    case (len)
      3'b001:  return 1;
      3'b010:  return 2;
      3'b100:  return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] len);
    int n;
    int m;
    n = nbytes(len);
    m = ((1 << n) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic model_legal(input logic [31:0] a, input logic [2:0] len,
                                       input logic rd, input logic wr);
    int n;
    n = nbytes(len);
    if (n == 0) return 1'b0;
    return ((int'(a[1:0]) % n) == 0) && (rd != wr);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (HLT) hlt_cnt++;
      if (MEM_RE | MEM_WE) begin
        strobe_cnt++;
        last_be    = MEM_BE;
        last_maddr = MEM_ADDR;
        last_wdata = MEM_WDATA;
      end
      chk("hlt", {31'b0, HLT}, {31'b0, exp_hlt});
      chk("mem_re", {31'b0, MEM_RE}, {31'b0, exp_re});
      chk("mem_we", {31'b0, MEM_WE}, {31'b0, exp_we});
      chk("datai", DATAI, exp_datai);
      chk("bus_err", {31'b0, BUS_ERR}, {31'b0, exp_bus_err});
      chk("err_addr", ERR_ADDR, exp_err_addr);
      if (exp_re | exp_we) begin
        chk("mem_be", {28'b0, MEM_BE}, {28'b0, exp_be});
        chk("mem_addr", {2'b0, MEM_ADDR}, {2'b0, exp_maddr});
        chk("mem_wdata", MEM_WDATA, exp_wdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one cycle: registered expectations take their next values and
  // inputs fall back to quiet.
  task automatic step();
    @(posedge clk);
    #1;
    exp_datai    = nxt_datai;
    exp_bus_err  = nxt_bus_err;
    exp_err_addr = nxt_err_addr;
    exp_hlt = 1'b0;
    exp_re  = 1'b0;
    exp_we  = 1'b0;
    DAS     = 1'b0;
    MEM_ACK = 1'b0;
    ERR_CLR = 1'b0;
  endtask

  task automatic finish_cycle(input logic err, input logic [31:0] eaddr);
    if (err) begin
      nxt_bus_err  = 1'b1;
      nxt_err_addr = eaddr;
    end else if (ERR_CLR) begin
      nxt_bus_err = 1'b0;
    end
  endtask

  task automatic do_access(input logic [31:0] a, input logic [2:0] len,
                           input logic rd, input logic wr, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] rdata,
                           input logic clr, input logic das_in_resp);
    logic done;
    step();
    DADDR = a; DLEN = len; DRD = rd; DWR = wr; DATAO = wd; DAS = 1'b1; ERR_CLR = clr;
    if (!(rd | wr)) begin
      finish_cycle(1'b0, 32'h0);
    end else if (!model_legal(a, len, rd, wr)) begin
      nxt_datai = 32'h0;
      finish_cycle(1'b1, a);
    end else begin
      exp_hlt = 1'b1;
      finish_cycle(1'b0, 32'h0);
      done = 1'b0;
      for (int k = 1; k <= TO && !done; k++) begin
        step();
        // Scramble CPU-side inputs: memory side must use the captured copy.
        DADDR = ~a; DATAO = ~wd; DRD = 1'b0; DWR = 1'b0;
        exp_hlt = 1'b1; exp_re = rd; exp_we = wr;
        exp_be = model_be(a, len); exp_maddr = a[31:2]; exp_wdata = wd;
        if (k == ack_at) begin
          MEM_ACK = 1'b1; MEM_RDATA = rdata;
          if (rd) nxt_datai = rdata;
          finish_cycle(1'b0, 32'h0);
          done = 1'b1;
        end else if (k == TO) begin
          if (rd) nxt_datai = 32'hFFFF_FFFF;
          finish_cycle(1'b1, a);
          done = 1'b1;
        end else begin
          finish_cycle(1'b0, 32'h0);
        end
      end
      // RESP cycle; an (illegal) request offered here must be ignored.
      step();
      if (das_in_resp) begin
        DAS = 1'b1; DRD = 1'b1; DADDR = 32'h0000_0005; DLEN = 3'b010;
      end
      finish_cycle(1'b0, 32'h0);
    end
    step();
    finish_cycle(1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_datai"}, DATAI, 32'h0);
    chk({p, "_hlt"}, {31'b0, HLT}, 32'h0);
    chk({p, "_re_we"}, {30'b0, MEM_RE, MEM_WE}, 32'h0);
    chk({p, "_be"}, {28'b0, MEM_BE}, 32'h0);
    chk({p, "_maddr"}, {2'b0, MEM_ADDR}, 32'h0);
    chk({p, "_wdata"}, MEM_WDATA, 32'h0);
    chk({p, "_bus_err"}, {31'b0, BUS_ERR}, 32'h0);
    chk({p, "_err_addr"}, ERR_ADDR, 32'h0);
  endtask

  task automatic clear_model();
    exp_hlt = 1'b0; exp_re = 1'b0; exp_we = 1'b0; exp_be = 4'b0;
    exp_maddr = '0; exp_wdata = '0;
    exp_datai = '0; exp_bus_err = 1'b0; exp_err_addr = '0;
    nxt_datai = '0; nxt_bus_err = 1'b0; nxt_err_addr = '0;
  endtask

  // ---------------- main sequence ----------------
  int h0, s0;

  initial begin
    DADDR = '0; DATAO = '0; DLEN = 3'b100; DRD = 1'b0; DWR = 1'b0; DAS = 1'b0;
    MEM_RDATA = '0; MEM_ACK = 1'b0; ERR_CLR = 1'b0;
    clear_model();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Word read, ack on the 3rd REQ cycle; an ignored request in RESP.
    h0 = hlt_cnt; s0 = strobe_cnt;
    do_access(32'h0000_1000, 3'b100, 1'b1, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("word_rd_hlt_cycles", 32'(hlt_cnt - h0), 32'd4);
    chk("word_rd_maddr", {2'b0, last_maddr}, 32'h0000_0400);
    chk("word_rd_be", {28'b0, last_be}, 32'h0000_000F);
    chk("word_rd_datai", DATAI, 32'hDEAD_BEEF);
    chk("word_rd_no_err", {31'b0, BUS_ERR}, 32'h0);

    // Byte write at lane 3, immediate ack.
    h0 = hlt_cnt; s0 = strobe_cnt;
    do_access(32'h0000_0003, 3'b001, 1'b0, 1'b1, 32'hAA00_0000, 1, 32'h5555_5555, 1'b0, 1'b0);
    chk("byte_wr_hlt_cycles", 32'(hlt_cnt - h0), 32'd2);
    chk("byte_wr_strobes", 32'(strobe_cnt - s0), 32'd1);
    chk("byte_wr_be", {28'b0, last_be}, 32'h0000_0008);
    chk("byte_wr_wdata", last_wdata, 32'hAA00_0000);
    chk("byte_wr_datai_kept", DATAI, 32'hDEAD_BEEF);

    // Upper half read and a byte read.
    do_access(32'h0000_0006, 3'b010, 1'b1, 1'b0, 32'h0, 2, 32'h1234_5678, 1'b0, 1'b0);
    chk("half_rd_be", {28'b0, last_be}, 32'h0000_000C);
    do_access(32'h0000_0201, 3'b001, 1'b1, 1'b0, 32'h0, 1, 32'h00C3_0000, 1'b0, 1'b0);
    chk("byte_rd_be", {28'b0, last_be}, 32'h0000_0002);

    // Misaligned half read.
    h0 = hlt_cnt; s0 = strobe_cnt;
    do_access(32'h0000_0005, 3'b010, 1'b1, 1'b0, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    chk("mis_half_strobes", 32'(strobe_cnt - s0), 32'd0);
    chk("mis_half_hlt", 32'(hlt_cnt - h0), 32'd0);
    chk("mis_half_bus_err", {31'b0, BUS_ERR}, 32'h1);
    chk("mis_half_err_addr", ERR_ADDR, 32'h0000_0005);
    chk("mis_half_datai", DATAI, 32'h0);

    // DAS with no direction plus ERR_CLR: no request, flag clears.
    s0 = strobe_cnt;
    do_access(32'h0000_0010, 3'b100, 1'b0, 1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    chk("clr_alone_bus_err", {31'b0, BUS_ERR}, 32'h0);
    chk("no_dir_strobes", 32'(strobe_cnt - s0), 32'd0);

    // ERR_CLR coincident with a misaligned word: error wins.
    do_access(32'h0000_0002, 3'b100, 1'b1, 1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b0);
    chk("clr_vs_err_bus_err", {31'b0, BUS_ERR}, 32'h1);
    chk("clr_vs_err_addr", ERR_ADDR, 32'h0000_0002);

    // Non-one-hot size, then both directions at once.
    do_access(32'h0000_0000, 3'b011, 1'b1, 1'b0, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    do_access(32'h0000_0020, 3'b100, 1'b1, 1'b1, 32'h0, 1, 32'h0, 1'b0, 1'b0);
    chk("rdwr_err_addr", ERR_ADDR, 32'h0000_0020);
    do_access(32'h0, 3'b100, 1'b0, 1'b0, 32'h0, 1, 32'h0, 1'b1, 1'b0);

    // Timeout on a read with no ack.
    h0 = hlt_cnt;
    do_access(32'h0000_0040, 3'b100, 1'b1, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    chk("timeout_hlt_cycles", 32'(hlt_cnt - h0), 32'd5);
    chk("timeout_datai", DATAI, 32'hFFFF_FFFF);
    chk("timeout_bus_err", {31'b0, BUS_ERR}, 32'h1);
    chk("timeout_err_addr", ERR_ADDR, 32'h0000_0040);

    // Ack on the last allowed cycle completes normally.
    h0 = hlt_cnt;
    do_access(32'h0000_0044, 3'b100, 1'b1, 1'b0, 32'h0, TO, 32'h0BAD_F00D, 1'b0, 1'b0);
    chk("late_ack_hlt_cycles", 32'(hlt_cnt - h0), 32'd5);
    chk("late_ack_datai", DATAI, 32'h0BAD_F00D);
    chk("late_ack_err_addr", ERR_ADDR, 32'h0000_0040);

    // Write timeout leaves DATAI alone.
    do_access(32'h0000_0048, 3'b100, 1'b0, 1'b1, 32'hCAFE_0001, 0, 32'h0, 1'b0, 1'b0);
    chk("wr_timeout_datai", DATAI, 32'h0BAD_F00D);
    chk("wr_timeout_err_addr", ERR_ADDR, 32'h0000_0048);

    // Spurious ack while idle.
    step();
    MEM_ACK = 1'b1; MEM_RDATA = 32'h1111_1111;
    finish_cycle(1'b0, 32'h0);
    step();
    finish_cycle(1'b0, 32'h0);

    // Reset in the middle of a REQ.
    step();
    DADDR = 32'h0000_0080; DLEN = 3'b100; DRD = 1'b1; DWR = 1'b0; DATAO = 32'h0; DAS = 1'b1;
    exp_hlt = 1'b1;
    finish_cycle(1'b0, 32'h0);
    step();
    DRD = 1'b0;
    exp_hlt = 1'b1; exp_re = 1'b1; exp_be = 4'hF; exp_maddr = 30'h20; exp_wdata = 32'h0;
    finish_cycle(1'b0, 32'h0);
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("mid_req_reset");
    clear_model();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 1) begin
        MEM_ACK = 1'b1; MEM_RDATA = 32'h2222_2222;
      end
      finish_cycle(1'b0, 32'h0);
    end
    chk("post_reset_strobes", 32'(strobe_cnt - s0), 32'd0);

    // Normal service after reset.
    do_access(32'h0000_0100, 3'b100, 1'b0, 1'b1, 32'h0102_0304, 2, 32'h0, 1'b0, 1'b0);
    chk("post_reset_wr_maddr", {2'b0, last_maddr}, 32'h0000_0040);

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
